// File: rtl/rvv_alu_pkg.sv
// Shared encodings for the sequenced RVV integer ALU: funct6/op_type codes,
// FSM and compare-decision states, SEW decode.
package rvv_alu_pkg;

  localparam logic [5:0] OP_VADD  = 6'b000000;
  localparam logic [5:0] OP_VSUB  = 6'b000010;
  localparam logic [5:0] OP_VRSUB = 6'b000011;
  localparam logic [5:0] OP_VMINU = 6'b000100;
  localparam logic [5:0] OP_VMIN  = 6'b000101;
  localparam logic [5:0] OP_VMAXU = 6'b000110;
  localparam logic [5:0] OP_VMAX  = 6'b000111;
  localparam logic [5:0] OP_VAND  = 6'b001001;
  localparam logic [5:0] OP_VOR   = 6'b001010;
  localparam logic [5:0] OP_VXOR  = 6'b001011;

  localparam logic [2:0] OPT_VV = 3'b001;
  localparam logic [2:0] OPT_VX = 3'b010;
  localparam logic [2:0] OPT_VI = 3'b100;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_e;
  typedef enum logic [1:0] {CMP_UND, CMP_LT, CMP_GE} cmp_e;

  function automatic logic [6:0] sew_bits(input logic [1:0] vsew);
    return 7'd8 << vsew;
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return op inside {OP_VADD, OP_VSUB, OP_VRSUB, OP_VMINU, OP_VMIN,
                      OP_VMAXU, OP_VMAX, OP_VAND, OP_VOR, OP_VXOR};
  endfunction

  function automatic logic is_minmax(input logic [5:0] op);
    return op inside {OP_VMINU, OP_VMIN, OP_VMAXU, OP_VMAX};
  endfunction

  function automatic logic is_signed_cmp(input logic [5:0] op);
    return (op == OP_VMIN) || (op == OP_VMAX);
  endfunction

endpackage

// File: rtl/rvv_alu_lane.sv
// One LANE_W-wide chunk datapath. Carries add/sub carry and the min/max
// decision across the chunks of one element; both clear after the last chunk.
module rvv_alu_lane
  import rvv_alu_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic              top_i,
  input  logic [5:0]        opcode_i,
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] res_o
);

  logic              carry_q, carry_d;
  cmp_e              cmp_q, cmp_d;
  cmp_e              cur, dec;
  logic              cin, lt;
  logic [LANE_W-1:0] x, y;
  logic [LANE_W:0]   sum;

  always_comb begin
    x   = a_i;
    y   = b_i;
    cin = first_i ? 1'b0 : carry_q;
    case (opcode_i)
      OP_VSUB: begin
        y = ~b_i;
        if (first_i) cin = 1'b1;
      end
      OP_VRSUB: begin
        x = b_i;
        y = ~a_i;
        if (first_i) cin = 1'b1;
      end
      default: ;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{LANE_W{1'b0}}, cin};

    // Signedness only matters on the element's top chunk.
    cur = first_i ? CMP_UND : cmp_q;
    lt  = (top_i && is_signed_cmp(opcode_i)) ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
    dec = cur;
    if (cur == CMP_UND && a_i != b_i) dec = lt ? CMP_LT : CMP_GE;

    case (opcode_i)
      OP_VADD, OP_VSUB, OP_VRSUB: res_o = sum[LANE_W-1:0];
      OP_VMINU, OP_VMIN:          res_o = (dec == CMP_LT) ? a_i : b_i;
      OP_VMAXU, OP_VMAX:          res_o = (dec == CMP_LT) ? b_i : a_i;
      OP_VAND:                    res_o = a_i & b_i;
      OP_VOR:                     res_o = a_i | b_i;
      OP_VXOR:                    res_o = a_i ^ b_i;
      default:                    res_o = a_i;
    endcase

    carry_d = carry_q;
    cmp_d   = cmp_q;
    if (en_i) begin
      carry_d = last_i ? 1'b0 : sum[LANE_W];
      cmp_d   = last_i ? CMP_UND : dec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      carry_q <= 1'b0;
      cmp_q   <= CMP_UND;
    end else begin
      carry_q <= carry_d;
      cmp_q   <= cmp_d;
    end
  end

endmodule

// File: rtl/rvv_alu_seq.sv
// Self-sequencing RVV integer ALU: runs one vector instruction over NL lanes,
// one chunk per lane per cycle, with v0 masking and tail-undisturbed writeback.
module rvv_alu_seq
  import rvv_alu_pkg::*;
#(
  parameter  int VLEN          = 128,
  parameter  int LANE_WIDTH    = 3,
  parameter  int NB_LANES_LOG2 = 1,
  localparam int VL_W          = $clog2(VLEN/8+1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [5:0]      opcode_i,
  input  logic [2:0]      op_type_i,
  input  logic [2:0]      vsew_i,
  input  logic [VL_W-1:0] vl_i,
  input  logic            vm_i,
  input  logic [VLEN-1:0] vs1_i,
  input  logic [VLEN-1:0] vs2_i,
  input  logic [VLEN-1:0] vd_old_i,
  input  logic [VLEN-1:0] v0_i,
  input  logic [63:0]     rs1_i,
  input  logic [4:0]      imm_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            illegal_o,
  output logic [VLEN-1:0] vd_out_o
);

  localparam int          LANE_W  = 1 << LANE_WIDTH;
  localparam int          NL      = 1 << NB_LANES_LOG2;
  localparam int          IW      = 16;
  localparam logic [6:0]  LANE_W7 = 7'(LANE_W);

  state_e          state_q, state_d;
  logic [5:0]      op_q;
  logic [2:0]      opt_q;
  logic [1:0]      sew_q;
  logic [VL_W-1:0] vl_q;
  logic            vm_q, illegal_q, cap;
  logic [VLEN-1:0] vs1_q, vs2_q, v0_q, vd_q, vd_d;
  logic [63:0]     scalar_q;
  logic [IW-1:0]   grp_q, grp_d;
  logic [6:0]      chk_q, chk_d;

  // Start-time decode
  logic            ill_in;
  logic [VL_W-1:0] vlmax_in, vl_cl;
  logic [63:0]     scalar_in;

  always_comb begin
    ill_in = !op_known(opcode_i) || vsew_i[2] ||
             !(op_type_i inside {OPT_VV, OPT_VX, OPT_VI}) ||
             (op_type_i == OPT_VI && is_minmax(opcode_i));
    vlmax_in  = VL_W'(VLEN >> (3 + vsew_i[1:0]));
    vl_cl     = (vl_i > vlmax_in) ? vlmax_in : vl_i;
    scalar_in = (op_type_i == OPT_VI) ? {{59{imm_i[4]}}, imm_i} : rs1_i;
  end

  // Chunk geometry for the running instruction
  logic [6:0]        sew_w, cw, cpe, ck;
  logic              mm, sgn, first, last_chk, last_grp, top;
  logic [LANE_W-1:0] cmask;

  always_comb begin
    sew_w    = sew_bits(sew_q);
    cw       = (sew_w < LANE_W7) ? sew_w : LANE_W7;
    cpe      = (sew_w > LANE_W7) ? (sew_w >> LANE_WIDTH) : 7'd1;
    mm       = is_minmax(op_q);
    sgn      = is_signed_cmp(op_q);
    first    = (chk_q == 7'd0);
    last_chk = (chk_q == cpe - 7'd1);
    // min/max walk chunks MSB-first, everything else LSB-first.
    ck       = mm ? (cpe - 7'd1 - chk_q) : chk_q;
    top      = (ck == cpe - 7'd1);
    last_grp = ((grp_q + IW'(1)) << NB_LANES_LOG2) >= IW'(vl_q);
    cmask    = {LANE_W{1'b1}} >> (LANE_W7 - cw);
  end

  // Narrow elements sit in the low cw bits; sign-extend for signed compares.
  function automatic logic [LANE_W-1:0] fit(input logic [LANE_W-1:0] raw,
                                            input logic [LANE_W-1:0] m,
                                            input logic [6:0] w, input logic sx);
    logic [LANE_W-1:0] v;
    v = raw & m;
    if (sx && (w < LANE_W7) && 1'(v >> (w - 7'd1))) v = v | ~m;
    return v;
  endfunction

  logic [NL-1:0][VLEN-1:0] wmask, wdata;

  for (genvar l = 0; l < NL; l++) begin : g_lane
    logic [IW-1:0]     e, off, soff;
    logic              act, we;
    logic [LANE_W-1:0] a, b, res;

    assign e    = IW'(grp_q << NB_LANES_LOG2) + IW'(l);
    assign act  = (state_q == ST_RUN) && (e < IW'(vl_q));
    assign soff = IW'(ck) * IW'(cw);
    assign off  = e * IW'(sew_w) + soff;
    assign a    = fit(LANE_W'(vs2_q >> off), cmask, cw, sgn);
    assign b    = fit((opt_q == OPT_VV) ? LANE_W'(vs1_q >> off) : LANE_W'(scalar_q >> soff),
                      cmask, cw, sgn);
    assign we   = act && (vm_q || 1'(v0_q >> e));

    rvv_alu_lane #(.LANE_W(LANE_W)) u_lane (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .en_i     (act),
      .first_i  (first),
      .last_i   (last_chk),
      .top_i    (top),
      .opcode_i (op_q),
      .a_i      (a),
      .b_i      (b),
      .res_o    (res)
    );

    assign wmask[l] = we ? (VLEN'(cmask) << off) : '0;
    assign wdata[l] = VLEN'(res) << off;
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    chk_d   = chk_q;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) begin
        cap     = 1'b1;
        grp_d   = '0;
        chk_d   = '0;
        state_d = (ill_in || vl_i == '0) ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        if (last_chk) begin
          chk_d = '0;
          grp_d = grp_q + IW'(1);
          if (last_grp) state_d = ST_FIN;
        end else begin
          chk_d = chk_q + 7'd1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vd_d = vd_q;
    if (cap) begin
      vd_d = vd_old_i;
    end else if (state_q == ST_RUN) begin
      for (int l = 0; l < NL; l++) vd_d = (vd_d & ~wmask[l]) | (wdata[l] & wmask[l]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      grp_q     <= '0;
      chk_q     <= '0;
      vd_q      <= '0;
      op_q      <= '0;
      opt_q     <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      illegal_q <= 1'b0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      v0_q      <= '0;
      scalar_q  <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      chk_q   <= chk_d;
      vd_q    <= vd_d;
      if (cap) begin
        op_q      <= opcode_i;
        opt_q     <= op_type_i;
        sew_q     <= vsew_i[1:0];
        vl_q      <= vl_cl;
        vm_q      <= vm_i;
        illegal_q <= ill_in;
        vs1_q     <= vs1_i;
        vs2_q     <= vs2_i;
        v0_q      <= v0_i;
        scalar_q  <= scalar_in;
      end
    end
  end

  assign busy_o    = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_FIN);
  assign illegal_o = done_o && illegal_q;
  assign vd_out_o  = vd_q;

endmodule
